// File: rtl/ring_pkg.sv
// Shared packet layout, routing constants and helpers for the ring NIC.
// Optional RING_NIC_STATS_EN in ring_nic adds injection/ejection counters.
package ring_pkg;

   localparam int NUM_NODES = 4;
   localparam int NODE_W    = 2;
   localparam int DATA_W    = 32;
   localparam int ENTRY_W   = NODE_W + DATA_W;
   localparam int PKT_W     = 64;

   localparam int VC_BIT    = 63;
   localparam int DIR_BIT   = 62;
   localparam int RSVD_LSB  = 56;
   localparam int RSVD_W    = 6;
   localparam int HOP_LSB   = 48;
   localparam int HOP_W     = 8;
   localparam int SRC_LSB   = 32;
   localparam int SRC_W     = 16;
   localparam int DATA_LSB  = 0;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   localparam logic [HOP_W-1:0] HOP_NEAR = 8'h01;
   localparam logic [HOP_W-1:0] HOP_FAR  = 8'h03;

   typedef struct packed {
      logic [NODE_W-1:0] node;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef struct packed {
      logic              vc;
      logic              dir;
      logic [RSVD_W-1:0] rsvd;
      logic [HOP_W-1:0]  hop;
      logic [SRC_W-1:0]  src;
      logic [DATA_W-1:0] data;
   } pkt_t;

   typedef struct packed {
      logic             loopback;
      logic             dir;
      logic [HOP_W-1:0] hop;
   } route_t;

   // Offset is (dest - self) mod 4; 0 means the packet never leaves the NIC.
   function automatic route_t route(input logic [NODE_W-1:0] off);
      route_t r;
      r.loopback = 1'b0;
      r.dir      = DIR_CW;
      r.hop      = HOP_NEAR;
      unique case (off)
         2'd0: r.loopback = 1'b1;
         2'd1: r.hop      = HOP_NEAR;
         2'd2: r.hop      = HOP_FAR;
         2'd3: r.dir      = DIR_CCW;
         default: r.loopback = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ring_nic_fifo.sv
// Synchronous FIFO with occupancy count; head is read straight from storage.
// DEPTH must be a power of two so the pointers wrap naturally.
module ring_nic_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ring_nic.sv
// Ring NIC: builds ring packets from CPU payloads, buffers ejections, loops back self traffic.
// Define RING_NIC_STATS_EN to add tx_pkt_cnt / rx_pkt_cnt ring traffic counters.
module ring_nic
   import ring_pkg::*;
#(
   parameter int NODE_ID  = 0,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_tx_valid,
   output logic        cpu_tx_ready,
   input  logic [1:0]  cpu_tx_dest,
   input  logic [31:0] cpu_tx_data,
   output logic        cpu_rx_valid,
   input  logic        cpu_rx_ready,
   output logic [1:0]  cpu_rx_src,
   output logic [31:0] cpu_rx_data,
   input  logic        polarity,
   output logic        pesi,
   output logic [63:0] pedi,
   input  logic        peri,
   input  logic        peso,
   input  logic [63:0] pedo,
   output logic        pero
`ifdef RING_NIC_STATS_EN
   ,
   output logic [15:0] tx_pkt_cnt,
   output logic [15:0] rx_pkt_cnt
`endif
);

   localparam int TXA = $clog2(TX_DEPTH);
   localparam int RXA = $clog2(RX_DEPTH);
   localparam logic [NODE_W-1:0] NODE = NODE_W'(NODE_ID);

   logic [ENTRY_W-1:0] tx_raw;
   logic [ENTRY_W-1:0] rx_raw;
   logic [ENTRY_W-1:0] rx_in;
   logic [TXA:0]       tx_count;
   logic [RXA:0]       rx_count;
   entry_t             tx_head;
   entry_t             rx_head;
   route_t             rt;
   pkt_t               pkt;

   logic tx_valid;
   logic tx_push;
   logic tx_pop;
   logic rx_push;
   logic rx_pop;
   logic inject;
   logic eject;
   logic loop_push;
   logic unused_pedo;

   assign tx_head = entry_t'(tx_raw);
   assign rx_head = entry_t'(rx_raw);

   // Counts are powers of two wide+1, so "not full" is just a clear MSB.
   assign cpu_tx_ready = ~tx_count[TXA];
   assign pero         = ~rx_count[RXA];
   assign tx_valid     = |tx_count;
   assign cpu_rx_valid = |rx_count;

   assign rt   = route(tx_head.node - NODE);
   assign pesi = tx_valid & ~rt.loopback;

   assign tx_push   = cpu_tx_valid & cpu_tx_ready;
   assign inject    = pesi & peri;
   assign eject     = peso & pero;
   // Ring ejection wins the single RX write port; loopback waits a cycle.
   assign loop_push = tx_valid & rt.loopback & pero & ~eject;
   assign tx_pop    = inject | loop_push;
   assign rx_push   = eject | loop_push;
   assign rx_pop    = cpu_rx_valid & cpu_rx_ready;

   assign rx_in = eject ? pedo[ENTRY_W-1:0] : {NODE, tx_head.data};

   always_comb begin
      pkt      = '0;
      pkt.vc   = polarity;
      pkt.dir  = rt.dir;
      pkt.hop  = rt.hop;
      pkt.src  = SRC_W'(NODE);
      pkt.data = tx_head.data;
   end

   assign pedi        = pesi ? pkt : '0;
   assign cpu_rx_src  = cpu_rx_valid ? rx_head.node : '0;
   assign cpu_rx_data = cpu_rx_valid ? rx_head.data : '0;

   assign unused_pedo = ^pedo[PKT_W-1:ENTRY_W];

   ring_nic_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push),
      .push_data ({cpu_tx_dest, cpu_tx_data}),
      .pop       (tx_pop),
      .head      (tx_raw),
      .count     (tx_count)
   );

   ring_nic_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_in),
      .pop       (rx_pop),
      .head      (rx_raw),
      .count     (rx_count)
   );

`ifdef RING_NIC_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_pkt_cnt <= '0;
         rx_pkt_cnt <= '0;
      end else begin
         if (inject) begin
            tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
         end
         if (eject) begin
            rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
